priority_decoder: RTL
=====================

PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 Parameter N, default 8: number of request lines rebuilt per frame.
REQ-002 Parameter CW, default 3: code width, fixed to log2(N).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port code, input, CW: index of one asserted request line, lowest index sent first.
REQ-006 Port code_valid, input, 1: code beat present.
REQ-007 Port code_last, input, 1: final beat of the current frame; qualified by code_valid.
REQ-008 Port code_ready, output, 1: block accepts a beat this cycle.
REQ-009 Port mask, output, N: rebuilt request vector of the completed frame.
REQ-010 Port count, output, CW+1: number of distinct bits set in mask, 0..N.
REQ-011 Port dup_err, output, 1: the frame contained a repeated code.
REQ-012 Port order_err, output, 1: the frame contained a code lower than the previous code.
REQ-013 Port out_valid, output, 1: mask, count, dup_err and order_err are valid.
REQ-014 Port out_ready, input, 1: consumer takes the frame result.

Function
REQ-015 A beat is accepted when code_valid and code_ready are both high.
REQ-016 code_ready = !out_valid || out_ready, so a new frame can start while the previous result drains.
REQ-017 FSM states:
- ACCUM: collecting beats.
- HOLD: result pending and accumulator empty.
REQ-018 Each accepted beat ORs the one-hot decode of code into the accumulator mask.
REQ-019 An accepted beat whose bit is already set in the accumulator sets the frame dup flag.
- The count does not change.
- The order flag is not set by that beat.
REQ-020 An accepted beat with code strictly less than the previous accepted code of the same frame sets the frame order flag.
REQ-021 An accepted beat with code_last high does all of the following at the next edge:
- transfers accumulator mask, popcount, dup flag and order flag (all including this beat) to the output registers;
- sets out_valid;
- clears the accumulator;
- enters HOLD.
Latency is one cycle.
REQ-022 Output registers remain stable while out_valid is high and out_ready is low.
REQ-023 A result handshake (out_valid and out_ready both high) without a new last beat clears out_valid and returns the FSM to ACCUM.
REQ-024 A result handshake and an accepted code_last beat in the same cycle load the new result; out_valid stays high.
REQ-025 A result handshake and an accepted non-last beat in the same cycle:
- clear out_valid;
- start the new frame with that beat.
REQ-026 The first beat of a frame never sets the order flag.
REQ-027 A single-beat frame (code_last on the first beat) produces mask with one bit set and count 1.
REQ-028 Frames longer than N beats are legal; count saturates at N by construction.

Reset
REQ-029 While reset is high at a clock edge, the block drives:
- mask = 0, count = 0;
- dup_err = 0, order_err = 0, out_valid = 0;
- accumulator, previous-code register and flags cleared;
- FSM in ACCUM.
REQ-030 Reset mid-frame or during HOLD discards the partial frame and any pending result; code_ready is high in the first cycle after reset.

Structure
REQ-031 A shared package holds:
- the FSM state enum (ACCUM, HOLD);
- default constants for N and CW.
REQ-032 The combinational CW-to-N one-hot decoder is a separate sub-module, onehot_decode, instantiated once.
REQ-033 The popcount is computed combinationally on the next-accumulator value and registered with mask.

Verification
REQ-034 Beats 1, 4, 6(last), out_ready high -> one cycle after beat 6: out_valid = 1, mask = 0x52, count = 3, both error flags 0.
REQ-035 Beats 0..7 ascending (last on 7) -> mask = 0xFF, count = 8; then single beat 5(last) -> mask = 0x20, count = 1.
REQ-036 Beats 2, 2(last) -> mask = 0x04, count = 1, dup_err = 1, order_err = 0.
REQ-037 Beats 7, 0(last) -> mask = 0x81, order_err = 1, dup_err = 0.
REQ-038 out_ready low with result pending -> code_ready = 0 and outputs stable for 5 cycles; then out_ready high with beat 3(last) in the same cycle -> next cycle out_valid = 1, mask = 0x08.
REQ-039 Beats 1, 2, then reset for one cycle, then 5(last) -> mask = 0x20, count = 1; out_valid is 0 in the cycle after reset.

Source files
------------

// File: rtl/priority_decoder_pkg.sv
// Shared types and defaults for the priority decoder slice.
// Holds the frame FSM state enum and default sizing constants.
package priority_decoder_pkg;

    localparam int N_DEF  = 8;
    localparam int CW_DEF = 3;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/priority_decoder_onehot_decode.sv
// Combinational CW-to-N one-hot decoder.
// Ports: code (CW) in, onehot (N) out with bit[code] set.
module onehot_decode #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic [CW-1:0] code,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (code == CW'(i));
        end
    end

endmodule

// File: rtl/priority_decoder.sv
// Rebuilds a request mask from a stream of codes, one frame at a time.
// Ports: clk, reset; code/code_valid/code_last/code_ready in-stream;
// mask/count/dup_err/order_err/out_valid/out_ready result handshake.
module priority_decoder
    import priority_decoder_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] code,
    input  logic          code_valid,
    input  logic          code_last,
    output logic          code_ready,
    output logic [N-1:0]  mask,
    output logic [CW:0]   count,
    output logic          dup_err,
    output logic          order_err,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        state;
    logic [N-1:0]  acc;
    logic [N-1:0]  dec;
    logic [N-1:0]  acc_nx;
    logic [CW-1:0] prev;
    logic          have_prev;
    logic          dup_f;
    logic          ord_f;
    logic          dup_nx;
    logic          ord_nx;
    logic          hit;
    logic          accept;
    logic          drain;
    logic [CW:0]   cnt_nx;

    onehot_decode #(
        .N  (N),
        .CW (CW)
    ) u_dec (
        .code   (code),
        .onehot (dec)
    );

    // A result is pending exactly when the FSM sits in HOLD.
    assign out_valid  = (state == HOLD);
    assign code_ready = !out_valid || out_ready;
    assign accept     = code_valid && code_ready;
    assign drain      = out_valid && out_ready;

    assign hit    = |(acc & dec);
    assign acc_nx = acc | dec;
    assign dup_nx = dup_f | hit;
    // A repeated code only flags dup, never order.
    assign ord_nx = ord_f | (have_prev && !hit && (code < prev));

    always_comb begin
        cnt_nx = '0;
        for (int i = 0; i < N; i++) begin
            cnt_nx = cnt_nx + (CW+1)'(acc_nx[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            dup_f     <= 1'b0;
            ord_f     <= 1'b0;
            mask      <= '0;
            count     <= '0;
            dup_err   <= 1'b0;
            order_err <= 1'b0;
        end else if (accept) begin
            if (code_last) begin
                mask      <= acc_nx;
                count     <= cnt_nx;
                dup_err   <= dup_nx;
                order_err <= ord_nx;
                acc       <= '0;
                prev      <= '0;
                have_prev <= 1'b0;
                dup_f     <= 1'b0;
                ord_f     <= 1'b0;
                state     <= HOLD;
            end else begin
                // Accepting in HOLD implies the result drains now.
                acc       <= acc_nx;
                prev      <= code;
                have_prev <= 1'b1;
                dup_f     <= dup_nx;
                ord_f     <= ord_nx;
                state     <= ACCUM;
            end
        end else if (drain) begin
            state <= ACCUM;
        end
    end

endmodule
